param_cpu: RTL and testbench

- Parametrised successor to the team's 4-bit teaching CPU, which drives the LED-matrix board.
- Separate program counter, Harvard program memory with an editor write port and a debug read port, and a clock-enabled FETCH/EXEC state machine.
- Adds run/step/halt control, Z flag, SUB and JZ.
- Sits between the d-pad editor/divider logic and the LED/matrix display.

---
 rtl/cpu_pkg.sv | 32 +++
 rtl/cpu_alu.sv | 56 +++++
 rtl/param_cpu.sv | 205 ++++++++++++++++++++
 tb/tb_param_cpu.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Opcodes, FSM state encoding and instruction-field slice constants for param_cpu.
package cpu_pkg;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned RSEL_W = 3;
  localparam int unsigned NREGS  = 8;
  localparam int unsigned RD_LSB = 3;
  localparam int unsigned RS_LSB = 0;

  localparam logic [OP_W-1:0] OP_NOP = 4'h0;
  localparam logic [OP_W-1:0] OP_MOV = 4'h1;
  localparam logic [OP_W-1:0] OP_ADD = 4'h2;
  localparam logic [OP_W-1:0] OP_SUB = 4'h3;
  localparam logic [OP_W-1:0] OP_AND = 4'h4;
  localparam logic [OP_W-1:0] OP_OR  = 4'h5;
  localparam logic [OP_W-1:0] OP_XOR = 4'h6;
  localparam logic [OP_W-1:0] OP_NOT = 4'h7;
  localparam logic [OP_W-1:0] OP_ROR = 4'h8;
  localparam logic [OP_W-1:0] OP_ROL = 4'h9;
  localparam logic [OP_W-1:0] OP_INC = 4'hA;
  localparam logic [OP_W-1:0] OP_MVI = 4'hB;
  localparam logic [OP_W-1:0] OP_JMP = 4'hC;
  localparam logic [OP_W-1:0] OP_JNC = 4'hD;
  localparam logic [OP_W-1:0] OP_JZ  = 4'hE;
  localparam logic [OP_W-1:0] OP_HLT = 4'hF;

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } state_e;
endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU: result plus per-op write enables for destination, C and Z.
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int unsigned DW = 4
) (
  input  logic [OP_W-1:0] op,
  input  logic [DW-1:0]   a,
  input  logic [DW-1:0]   b,
  input  logic            c_in,
  output logic [DW-1:0]   result,
  output logic            c_out,
  output logic            z_out,
  output logic            wr_en,
  output logic            c_wr,
  output logic            z_wr
);
  logic [DW:0] sum;

  always_comb begin
    result = a;
    c_out  = c_in;
    wr_en  = 1'b0;
    c_wr   = 1'b0;
    z_wr   = 1'b0;
    sum    = '0;
    case (op)
      OP_MOV, OP_MVI: begin result = b; wr_en = 1'b1; end
      OP_ADD: begin
        sum = {1'b0, a} + {1'b0, b};
        result = sum[DW-1:0]; c_out = sum[DW];
        wr_en = 1'b1; c_wr = 1'b1; z_wr = 1'b1;
      end
      // Bit DW of the widened difference is the unsigned borrow.
      OP_SUB: begin
        sum = {1'b0, a} - {1'b0, b};
        result = sum[DW-1:0]; c_out = sum[DW];
        wr_en = 1'b1; c_wr = 1'b1; z_wr = 1'b1;
      end
      OP_INC: begin
        sum = {1'b0, a} + (DW+1)'(1);
        result = sum[DW-1:0]; c_out = sum[DW];
        wr_en = 1'b1; c_wr = 1'b1; z_wr = 1'b1;
      end
      OP_AND: begin result = a & b; wr_en = 1'b1; z_wr = 1'b1; end
      OP_OR:  begin result = a | b; wr_en = 1'b1; z_wr = 1'b1; end
      OP_XOR: begin result = a ^ b; wr_en = 1'b1; z_wr = 1'b1; end
      OP_NOT: begin result = ~a;    wr_en = 1'b1; z_wr = 1'b1; end
      OP_ROR: begin result = {a[0], a[DW-1:1]};    wr_en = 1'b1; z_wr = 1'b1; end
      OP_ROL: begin result = {a[DW-2:0], a[DW-1]}; wr_en = 1'b1; z_wr = 1'b1; end
      default: ;
    endcase
  end

  assign z_out = (result == '0);
endmodule

// File: rtl/param_cpu.sv
// Parametrised teaching CPU: Harvard program memory, FETCH/EXEC FSM with run/step/halt.
// Optional breakpoint unit enabled by defining CPU_BREAKPOINT_EN.
module param_cpu
  import cpu_pkg::*;
#(
  parameter int unsigned DW      = 4,
  parameter int unsigned AW      = 6,
  parameter int unsigned OUT_REG = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ce,
  input  logic               run,
  input  logic               step,
  input  logic               resume,
  input  logic               mem_we,
  input  logic [AW-1:0]      mem_waddr,
  input  logic [AW+OP_W-1:0] mem_wdata,
  input  logic [AW-1:0]      dbg_addr,
  output logic [AW+OP_W-1:0] dbg_data,
  input  logic [RSEL_W-1:0]  reg_sel,
  output logic [DW-1:0]      reg_data,
  output logic [AW-1:0]      pc,
  output logic [DW-1:0]      out_reg,
  output logic               c_flag,
  output logic               z_flag,
  output logic               halted,
  output logic               busy
`ifdef CPU_BREAKPOINT_EN
  ,
  input  logic               bp_en,
  input  logic [AW-1:0]      bp_addr,
  output logic               bp_hit
`endif
);
  localparam int unsigned IW    = OP_W + AW;
  localparam int unsigned DEPTH = 1 << AW;

  logic [IW-1:0] mem [DEPTH];

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [IW-1:0] ir_q, ir_d;
  logic [IW-1:0] dbg_data_q, dbg_data_d;
  logic [DW-1:0] regs_q [NREGS];
  logic [DW-1:0] regs_d [NREGS];
  logic          c_q, c_d, z_q, z_d;
  logic          step_pend_q, step_pend_d;

  logic [OP_W-1:0]   op;
  logic [AW-1:0]     f;
  logic [RSEL_W-1:0] wr_idx, rs_idx;
  logic [DW-1:0]     alu_a, alu_b, alu_res;
  logic              alu_c, alu_z, alu_wr, alu_c_wr, alu_z_wr;
  logic              jump_taken;
  logic [AW-1:0]     pc_exec;

  // MVI reuses the MOV datapath with r0 as destination and the immediate as source.
  assign op     = ir_q[IW-1 -: OP_W];
  assign f      = ir_q[AW-1:0];
  assign rs_idx = f[RS_LSB +: RSEL_W];
  assign wr_idx = (op == OP_MVI) ? RSEL_W'(0) : f[RD_LSB +: RSEL_W];
  assign alu_a  = regs_q[wr_idx];
  assign alu_b  = (op == OP_MVI) ? DW'(f) : regs_q[rs_idx];

  always_comb begin
    case (op)
      OP_JMP:  jump_taken = 1'b1;
      OP_JNC:  jump_taken = !c_q;
      OP_JZ:   jump_taken = z_q;
      default: jump_taken = 1'b0;
    endcase
  end

  assign pc_exec = jump_taken ? f : pc_q + AW'(1);

  cpu_alu #(.DW(DW)) u_alu (
    .op     (op),
    .a      (alu_a),
    .b      (alu_b),
    .c_in   (c_q),
    .result (alu_res),
    .c_out  (alu_c),
    .z_out  (alu_z),
    .wr_en  (alu_wr),
    .c_wr   (alu_c_wr),
    .z_wr   (alu_z_wr)
  );

`ifdef CPU_BREAKPOINT_EN
  logic bp_hit_q, bp_hit_d, bp_skip_q, bp_skip_d, bp_match_c;
  // bp_skip lets the breakpointed instruction run once after resume.
  assign bp_match_c = bp_en && !bp_skip_q &&
                      (((state_q == ST_EXEC) ? pc_exec : pc_q) == bp_addr);
`endif

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    regs_d      = regs_q;
    c_d         = c_q;
    z_d         = z_q;
    step_pend_d = step_pend_q;
    dbg_data_d  = mem[dbg_addr];
`ifdef CPU_BREAKPOINT_EN
    bp_hit_d    = bp_hit_q;
    bp_skip_d   = bp_skip_q;
`endif
    if (step && !run && !step_pend_q && (state_q == ST_STOP || state_q == ST_HALT))
      step_pend_d = 1'b1;
    case (state_q)
      ST_STOP: if (ce && (run || step_pend_q)) begin
        state_d = ST_FETCH;
`ifdef CPU_BREAKPOINT_EN
        if (bp_match_c) begin
          state_d  = ST_HALT;
          bp_hit_d = 1'b1;
        end else begin
          bp_skip_d = 1'b0;
        end
`endif
      end
      ST_FETCH: if (ce) begin
        ir_d    = mem[pc_q];
        state_d = ST_EXEC;
      end
      ST_EXEC: if (ce) begin
        pc_d        = pc_exec;
        step_pend_d = 1'b0;
        if (alu_wr)   regs_d[wr_idx] = alu_res;
        if (alu_c_wr) c_d = alu_c;
        if (alu_z_wr) z_d = alu_z;
        if (op == OP_HLT) begin
          state_d = ST_HALT;
        end else if (run) begin
          state_d = ST_FETCH;
`ifdef CPU_BREAKPOINT_EN
          if (bp_match_c) begin
            state_d  = ST_HALT;
            bp_hit_d = 1'b1;
          end
`endif
        end else begin
          state_d = ST_STOP;
        end
      end
      ST_HALT: if (resume) begin
        state_d = ST_STOP;
`ifdef CPU_BREAKPOINT_EN
        bp_hit_d = 1'b0;
        if (bp_hit_q) bp_skip_d = 1'b1;
`endif
      end
      default: state_d = ST_STOP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_STOP;
      pc_q        <= '0;
      ir_q        <= '0;
      regs_q      <= '{default: '0};
      c_q         <= 1'b0;
      z_q         <= 1'b0;
      step_pend_q <= 1'b0;
      dbg_data_q  <= '0;
`ifdef CPU_BREAKPOINT_EN
      bp_hit_q    <= 1'b0;
      bp_skip_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      regs_q      <= regs_d;
      c_q         <= c_d;
      z_q         <= z_d;
      step_pend_q <= step_pend_d;
      dbg_data_q  <= dbg_data_d;
`ifdef CPU_BREAKPOINT_EN
      bp_hit_q    <= bp_hit_d;
      bp_skip_q   <= bp_skip_d;
`endif
    end
  end

  // Editor port: unreset storage, written in every state including reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign dbg_data = dbg_data_q;
  assign reg_data = regs_q[reg_sel];
  assign out_reg  = regs_q[RSEL_W'(OUT_REG)];
  assign pc       = pc_q;
  assign c_flag   = c_q;
  assign z_flag   = z_q;
  assign halted   = (state_q == ST_HALT);
  assign busy     = (state_q == ST_FETCH) || (state_q == ST_EXEC);
`ifdef CPU_BREAKPOINT_EN
  assign bp_hit   = bp_hit_q;
`endif
endmodule

// File: tb/tb_param_cpu.sv
// Directed self-checking bench for param_cpu (DW=4, AW=6, OUT_REG=6).
module tb_param_cpu;
  localparam int unsigned DW = 4;
  localparam int unsigned AW = 6;
  localparam int unsigned IW = 10;

  logic clk = 1'b0, rst = 1'b0, ce = 1'b0, run = 1'b0, step = 1'b0, resume = 1'b0, mem_we = 1'b0;
  logic [AW-1:0] mem_waddr = '0, dbg_addr = '0, pc;
  logic [IW-1:0] mem_wdata = '0, dbg_data;
  logic [2:0]    reg_sel = '0;
  logic [DW-1:0] reg_data, out_reg;
  logic          c_flag, z_flag, halted, busy;
`ifdef CPU_BREAKPOINT_EN
  logic          bp_en = 1'b0;
  logic [AW-1:0] bp_addr = '0;
  logic          bp_hit;
`endif

  int n_vec = 0, n_err = 0, busy_ticks = 0;
  bit ce_toggle = 1'b0;

  param_cpu #(.DW(DW), .AW(AW), .OUT_REG(6)) dut (
    .clk(clk), .rst(rst), .ce(ce), .run(run), .step(step), .resume(resume),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .reg_sel(reg_sel), .reg_data(reg_data),
    .pc(pc), .out_reg(out_reg), .c_flag(c_flag), .z_flag(z_flag),
    .halted(halted), .busy(busy)
`ifdef CPU_BREAKPOINT_EN
    , .bp_en(bp_en), .bp_addr(bp_addr), .bp_hit(bp_hit)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [IW-1:0] ins(input logic [3:0] op, input logic [5:0] f);
    return {op, f};
  endfunction

  task automatic tick();
    if (busy && ce) busy_ticks++;
    @(posedge clk);
    #1;
    if (ce_toggle) ce = ~ce;
  endtask

  task automatic wr(input int a, input logic [IW-1:0] d);
    mem_we = 1'b1; mem_waddr = AW'(a); mem_wdata = d;
    tick();
    mem_we = 1'b0;
  endtask

  task automatic chk_reg(input string tag, input int idx, input int exp);
    reg_sel = 3'(idx);
    #1;
    check(tag, 32'(reg_data), 32'(exp));
  endtask

  task automatic do_step();
    step = 1'b1; tick(); step = 1'b0;
    tick(); tick(); tick();
  endtask

  task automatic run_to_halt(input string tag, input int budget);
    int k;
    k = 0;
    while (!halted && k < budget) begin tick(); k++; end
    check(tag, 32'(halted), 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    // Reset held with run=1; program 1 loaded while in reset.
    rst = 1'b0; run = 1'b1; ce = 1'b1;
    tick(); tick(); tick();
    check("rst_pc", 32'(pc), 0);
    for (int i = 0; i < 8; i++) chk_reg($sformatf("rst_r%0d", i), i, 0);
    check("rst_c", 32'(c_flag), 0);
    check("rst_z", 32'(z_flag), 0);
    check("rst_halted", 32'(halted), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_dbg", 32'(dbg_data), 0);
    run = 1'b0;
    wr(0, ins(4'hB, 6'd9));
    wr(1, ins(4'h1, 6'd8));
    wr(2, ins(4'h2, 6'd9));
    wr(3, ins(4'hD, 6'd0));
    wr(4, ins(4'hF, 6'd0));
    rst = 1'b1; tick();

    // Program 1 free-running with ce every other clk.
    busy_ticks = 0; ce_toggle = 1'b1; run = 1'b1;
    run_to_halt("p1_halted", 100);
    run = 1'b0; ce_toggle = 1'b0; ce = 1'b1;
    chk_reg("p1_r1", 1, 2);
    chk_reg("p1_r0", 0, 9);
    check("p1_c", 32'(c_flag), 1);
    check("p1_z", 32'(z_flag), 0);
    check("p1_pc", 32'(pc), 5);
    check("p1_ce_ticks", 32'(busy_ticks), 10);

    // Program 2 single-stepped: SUB, JZ, step persistence through HALT.
    rst = 1'b0; tick();
    wr(0, ins(4'hB, 6'd5));  wr(1, ins(4'h1, 6'd8));
    wr(2, ins(4'hB, 6'd3));  wr(3, ins(4'h1, 6'd48));
    wr(4, ins(4'h3, 6'd1));  wr(5, ins(4'h3, 6'd0));
    wr(6, ins(4'hE, 6'd20)); wr(20, ins(4'hF, 6'd0));
    wr(21, ins(4'h0, 6'd0));
    rst = 1'b1; tick();
    step = 1'b1; tick(); step = 1'b0; tick(); step = 1'b1; tick(); step = 1'b0;
    repeat (4) tick();
    check("dstep_pc", 32'(pc), 1);
    check("dstep_busy", 32'(busy), 0);
    chk_reg("dstep_r0", 0, 5);
    do_step(); do_step(); do_step();
    check("p2_out_reg", 32'(out_reg), 3);
    chk_reg("p2_r1", 1, 5);
    do_step();
    chk_reg("sub1_r0", 0, 14);
    check("sub1_c", 32'(c_flag), 1);
    check("sub1_z", 32'(z_flag), 0);
    do_step();
    chk_reg("sub2_r0", 0, 0);
    check("sub2_c", 32'(c_flag), 0);
    check("sub2_z", 32'(z_flag), 1);
    do_step();
    check("jz_pc", 32'(pc), 20);
    do_step();
    check("hlt_halted", 32'(halted), 1);
    check("hlt_pc", 32'(pc), 21);
    step = 1'b1; tick(); step = 1'b0; tick();
    check("halt_step_held", 32'(halted), 1);
    resume = 1'b1; tick(); resume = 1'b0;
    repeat (4) tick();
    check("resume_step_pc", 32'(pc), 22);
    check("resume_halted", 32'(halted), 0);
    check("resume_busy", 32'(busy), 0);

    // Program 3: logic, rotate and INC ops free-running.
    rst = 1'b0; tick();
    wr(0, ins(4'hB, 6'd12)); wr(1, ins(4'h1, 6'd8));   wr(2, ins(4'hB, 6'd10));
    wr(3, ins(4'h1, 6'd17)); wr(4, ins(4'h1, 6'd24));  wr(5, ins(4'h4, 6'd8));
    wr(6, ins(4'h5, 6'd16)); wr(7, ins(4'h6, 6'd26));  wr(8, ins(4'h7, 6'd0));
    wr(9, ins(4'h8, 6'd8));  wr(10, ins(4'h9, 6'd16)); wr(11, ins(4'h8, 6'd0));
    wr(12, ins(4'h1, 6'd40)); wr(13, ins(4'hA, 6'd16)); wr(14, ins(4'h6, 6'd27));
    wr(15, ins(4'hB, 6'd15)); wr(16, ins(4'h1, 6'd32)); wr(17, ins(4'hA, 6'd32));
    wr(18, ins(4'hF, 6'd0));
    rst = 1'b1; tick();
    run = 1'b1;
    run_to_halt("p3_halted", 200);
    run = 1'b0;
    chk_reg("p3_r0", 0, 15);
    chk_reg("p3_r1_and_ror", 1, 4);
    chk_reg("p3_r2_or_rol_inc", 2, 14);
    chk_reg("p3_r3_xor", 3, 0);
    chk_reg("p3_r4_inc_wrap", 4, 0);
    chk_reg("p3_r5_not_ror", 5, 10);
    check("p3_c", 32'(c_flag), 1);
    check("p3_z", 32'(z_flag), 1);
    check("p3_pc", 32'(pc), 19);

    // PC wrap at 63 and read-first editor write during FETCH.
    rst = 1'b0; tick();
    wr(0, ins(4'hC, 6'd63)); wr(63, ins(4'h0, 6'd0));
    rst = 1'b1; tick();
    do_step();
    check("jmp63_pc", 32'(pc), 63);
    step = 1'b1; tick(); step = 1'b0; tick();
    check("fetch_busy", 32'(busy), 1);
    wr(63, ins(4'hF, 6'd0));
    tick();
    check("rdfirst_halted", 32'(halted), 0);
    check("wrap_pc", 32'(pc), 0);
    dbg_addr = 6'd63; tick();
    check("dbg_63", 32'(dbg_data), 32'h3C0);
    dbg_addr = 6'd0; tick();
    check("dbg_0", 32'(dbg_data), 32'h33F);
    do_step(); do_step();
    check("hlt63_halted", 32'(halted), 1);
    check("hlt63_pc_wrap", 32'(pc), 0);

    // Reset during EXEC of INC r2 with r2=15.
    rst = 1'b0; tick();
    wr(0, ins(4'hB, 6'd15)); wr(1, ins(4'h1, 6'd16)); wr(2, ins(4'hA, 6'd16));
    rst = 1'b1; tick();
    do_step(); do_step();
    chk_reg("pre_inc_r2", 2, 15);
    step = 1'b1; tick(); step = 1'b0; tick(); tick();
    check("exec_busy", 32'(busy), 1);
    rst = 1'b0; tick(); rst = 1'b1; tick();
    chk_reg("abort_r2", 2, 0);
    check("abort_c", 32'(c_flag), 0);
    check("abort_pc", 32'(pc), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_halted", 32'(halted), 0);

`ifdef CPU_BREAKPOINT_EN
    // Breakpoint at 3, then resume executes it once and runs to HLT at 5.
    rst = 1'b0; tick();
    for (int i = 0; i < 5; i++) wr(i, ins(4'h0, 6'd0));
    wr(5, ins(4'hF, 6'd0));
    bp_en = 1'b1; bp_addr = 6'd3;
    rst = 1'b1; tick();
    run = 1'b1;
    run_to_halt("bp_halted", 100);
    check("bp_pc", 32'(pc), 3);
    check("bp_hit", 32'(bp_hit), 1);
    resume = 1'b1; tick(); resume = 1'b0;
    check("bp_hit_clr", 32'(bp_hit), 0);
    run_to_halt("bp_resume_halted", 100);
    check("bp_resume_pc", 32'(pc), 6);
    check("bp_resume_hit", 32'(bp_hit), 0);
    run = 1'b0; bp_en = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
